// File: rtl/axil_req_arbiter_if.sv
// Bundle for the arbiter: per-requester command inputs and their completion
// returns, plus the shared command port towards the register-access engine.
//
// Handshake: a requester raises i_req with wr/addr/data and holds them stable
// until its one-cycle o_req_done (o_req_err marks a watchdog abort); the
// arbiter hands the winner's command to the engine as a one-cycle o_en strobe,
// and the engine completes it with a one-cycle i_done, with i_data qualified
// by i_data_vld at any point while the command is outstanding.
interface axil_req_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) ();
  logic [NUM_REQ-1:0]        i_req;
  logic [NUM_REQ-1:0]        i_req_wr;
  logic [NUM_REQ*ADDR_W-1:0] i_req_addr;
  logic [NUM_REQ*DATA_W-1:0] i_req_data;
  logic [NUM_REQ-1:0]        o_req_done;
  logic [NUM_REQ-1:0]        o_req_err;
  logic [DATA_W-1:0]         o_req_rdata;
  logic [NUM_REQ-1:0]        o_grant;
  logic                      o_en;
  logic                      o_wr;
  logic [ADDR_W-1:0]         o_addr;
  logic [DATA_W-1:0]         o_data;
  logic                      i_done;
  logic [DATA_W-1:0]         i_data;
  logic                      i_data_vld;
  logic                      o_busy;

  // Arbiter side
  modport slave (
    input  i_req, i_req_wr, i_req_addr, i_req_data, i_done, i_data, i_data_vld,
    output o_req_done, o_req_err, o_req_rdata, o_grant, o_en, o_wr, o_addr,
           o_data, o_busy
  );

  // Environment side: requesters and engine
  modport master (
    output i_req, i_req_wr, i_req_addr, i_req_data, i_done, i_data, i_data_vld,
    input  o_req_done, o_req_err, o_req_rdata, o_grant, o_en, o_wr, o_addr,
           o_data, o_busy
  );
endinterface

// File: rtl/axil_req_arbiter.sv
// Round-robin arbiter that shares one AXI-Lite register-access engine between
// NUM_REQ requesters. One command is in flight at a time; completion is
// bounded by a watchdog so a dead engine cannot hang the requesters.
module axil_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                 s_axi_lite_aclk,
  input  logic                 s_axi_lite_arst,
  axil_req_arbiter_if.slave    bus,
  output logic [1:0]           dbg_state
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t           state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] win_q;
  logic [CNT_W-1:0] wdog;
  logic [PTR_W-1:0] pick_idx;
  logic             pick_vld;
  logic [PTR_W:0]   cand;

  assign dbg_state  = state;
  assign bus.o_busy = (state != S_IDLE);

  // Round-robin search: first active request at or after rr_ptr, wrapping.
  always_comb begin
    pick_idx = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr} + (PTR_W+1)'(i);
      if (cand >= (PTR_W+1)'(NUM_REQ)) cand = cand - (PTR_W+1)'(NUM_REQ);
      if (!pick_vld && bus.i_req[cand[PTR_W-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = cand[PTR_W-1:0];
      end
    end
  end

  // Sequencer: arbitrate, strobe the engine, wait with watchdog, respond.
  always_ff @(posedge s_axi_lite_aclk or posedge s_axi_lite_arst) begin
    if (s_axi_lite_arst) begin
      state           <= S_IDLE;
      rr_ptr          <= '0;
      win_q           <= '0;
      wdog            <= '0;
      bus.o_req_done  <= '0;
      bus.o_req_err   <= '0;
      bus.o_req_rdata <= '0;
      bus.o_grant     <= '0;
      bus.o_en        <= 1'b0;
      bus.o_wr        <= 1'b0;
      bus.o_addr      <= '0;
      bus.o_data      <= '0;
    end else begin
      // Strobes default low so each is a single-cycle pulse
      bus.o_en       <= 1'b0;
      bus.o_req_done <= '0;
      bus.o_req_err  <= '0;
      case (state)
        S_IDLE: begin
          if (pick_vld) begin
            win_q       <= pick_idx;
            bus.o_wr    <= bus.i_req_wr[pick_idx];
            bus.o_addr  <= bus.i_req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
            bus.o_data  <= bus.i_req_data[int'(pick_idx)*DATA_W +: DATA_W];
            bus.o_grant <= NUM_REQ'(1) << pick_idx;
            bus.o_en    <= 1'b1;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wdog  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.i_data_vld) bus.o_req_rdata <= bus.i_data;
          // A completion on the terminal-count cycle wins over the timeout
          if (bus.i_done) begin
            bus.o_req_done[win_q] <= 1'b1;
            state                 <= S_RESP;
          end else if (wdog == CNT_W'(TIMEOUT-1)) begin
            bus.o_req_done[win_q] <= 1'b1;
            bus.o_req_err[win_q]  <= 1'b1;
            state                 <= S_RESP;
          end else begin
            wdog <= wdog + CNT_W'(1);
          end
        end
        S_RESP: begin
          if (win_q == PTR_W'(NUM_REQ-1)) rr_ptr <= '0;
          else                            rr_ptr <= win_q + PTR_W'(1);
          bus.o_grant <= '0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_req_arbiter.sv
// Bench for axil_req_arbiter: directed scenarios plus randomized traffic,
// checked against a transaction-level model of the arbitration rules.
module tb_axil_req_arbiter;

  localparam int N    = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int TMO  = 16;
  localparam int NONE = 1000;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  axil_req_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  axil_req_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) u_dut (
    .s_axi_lite_aclk (clk),
    .s_axi_lite_arst (rst),
    .bus             (bus.slave),
    .dbg_state       (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int            n_vec;
  int            n_err;
  logic [N-1:0]  exp_q[$];
  int            m_ptr;
  logic [DW-1:0] m_rdata;
  logic          r_wr   [N];
  logic [AW-1:0] r_addr [N];
  logic [DW-1:0] r_data [N];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Round-robin rule: first requester at or after the pointer, wrapping.
  function automatic int model_pick(input logic [N-1:0] reqs, input int ptr);
    for (int i = 0; i < N; i++)
      if (reqs[(ptr + i) % N]) return (ptr + i) % N;
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_fields();
    for (int k = 0; k < N; k++) begin
      bus.i_req_wr[k]              = r_wr[k];
      bus.i_req_addr[k*AW +: AW]   = r_addr[k];
      bus.i_req_data[k*DW +: DW]   = r_data[k];
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"}, bus.o_grant, 0);
    check({tag, "_en"},    bus.o_en, 0);
    check({tag, "_done"},  bus.o_req_done, 0);
    check({tag, "_err"},   bus.o_req_err, 0);
    check({tag, "_busy"},  bus.o_busy, 0);
    check({tag, "_wr"},    bus.o_wr, 0);
    check({tag, "_addr"},  bus.o_addr, 0);
    check({tag, "_data"},  bus.o_data, 0);
    check({tag, "_rdata"}, bus.o_req_rdata, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst            = 1'b1;
    bus.i_req      = '0;
    bus.i_done     = 1'b0;
    bus.i_data_vld = 1'b0;
    bus.i_data     = '0;
    repeat (2) @(negedge clk);
    check_all_zero("rst");
    rst     = 1'b0;
    m_ptr   = 0;
    m_rdata = '0;
  endtask

  // Called at a negedge in IDLE with a non-zero i_req; returns at the negedge
  // of the IDLE cycle after the response. lat = WAIT cycle (0-based) in which
  // the engine raises i_done; NONE means the engine never answers.
  task automatic run_txn(input int lat, input bit jitter, input bit fixed,
                         input logic [DW-1:0] fix_val,
                         output logic [N-1:0] g, output logic [N-1:0] dn,
                         output logic [N-1:0] er, output logic [DW-1:0] rd);
    int            w;
    bit            fire;
    bit            tmo;
    logic [N-1:0]  exp_g;
    logic          wr_l;
    logic [AW-1:0] addr_l;
    logic [DW-1:0] data_l;
    w = model_pick(bus.i_req, m_ptr);
    if (w < 0) w = 0;
    exp_g    = '0;
    exp_g[w] = 1'b1;
    exp_q.push_back(exp_g);
    wr_l   = r_wr[w];
    addr_l = r_addr[w];
    data_l = r_data[w];
    tmo    = 1'b0;
    fire   = 1'b0;

    // ISSUE cycle
    @(posedge clk); @(negedge clk);
    g = bus.o_grant;
    check("issue_grant", bus.o_grant, exp_q.pop_front());
    check("issue_en",    bus.o_en, 1);
    check("issue_wr",    bus.o_wr, wr_l);
    check("issue_addr",  bus.o_addr, addr_l);
    check("issue_data",  bus.o_data, data_l);
    check("issue_busy",  bus.o_busy, 1);
    // stray engine activity outside WAIT must be ignored
    bus.i_done     = (!fixed && $urandom_range(0, 3) == 0);
    bus.i_data_vld = (!fixed && $urandom_range(0, 3) == 0);
    bus.i_data     = $urandom;

    for (int c = 0; c < TMO; c++) begin
      @(posedge clk); @(negedge clk);
      check("wait_en",    bus.o_en, 0);
      check("wait_done",  bus.o_req_done, 0);
      check("wait_busy",  bus.o_busy, 1);
      check("wait_grant", bus.o_grant, exp_g);
      fire = (c == lat);
      tmo  = !fire && (c == TMO - 1);
      bus.i_done = fire;
      if (fire && !wr_l) begin
        bus.i_data_vld = 1'b1;
        bus.i_data     = fixed ? fix_val : DW'($urandom);
        m_rdata        = bus.i_data;
      end else if (!fixed && $urandom_range(0, 3) == 0) begin
        bus.i_data_vld = 1'b1;
        bus.i_data     = $urandom;
        m_rdata        = bus.i_data;
      end else begin
        bus.i_data_vld = 1'b0;
      end
      if (jitter) bus.i_req = N'($urandom_range(0, (1 << N) - 1));
      if (fire || tmo) break;
    end

    // RESP cycle
    @(posedge clk); @(negedge clk);
    dn = bus.o_req_done;
    er = bus.o_req_err;
    rd = bus.o_req_rdata;
    check("resp_done",  bus.o_req_done, exp_g);
    check("resp_err",   bus.o_req_err, tmo ? exp_g : '0);
    check("resp_rdata", bus.o_req_rdata, m_rdata);
    check("resp_en",    bus.o_en, 0);
    check("resp_busy",  bus.o_busy, 1);
    bus.i_req[w]   = 1'b0;
    bus.i_done     = (!fixed && $urandom_range(0, 3) == 0);
    bus.i_data_vld = (!fixed && $urandom_range(0, 3) == 0);
    bus.i_data     = $urandom;

    // back in IDLE
    @(posedge clk); @(negedge clk);
    bus.i_done     = 1'b0;
    bus.i_data_vld = 1'b0;
    check("idle_busy",  bus.o_busy, 0);
    check("idle_grant", bus.o_grant, 0);
    check("idle_done",  bus.o_req_done, 0);
    check("idle_err",   bus.o_req_err, 0);
    check("idle_en",    bus.o_en, 0);
    check("idle_addr",  bus.o_addr, addr_l);
    check("idle_wdata", bus.o_data, data_l);
    check("idle_rdata", bus.o_req_rdata, m_rdata);
    m_ptr = (w + 1) % N;
  endtask

  // ---------------- stimulus ----------------
  logic [N-1:0]  g, dn, er;
  logic [DW-1:0] rd;
  logic [N-1:0]  rr_order [5];

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    for (int k = 0; k < N; k++) begin
      r_wr[k]   = 1'b0;
      r_addr[k] = AW'(32'h0002_0000 + 32'(k) * 32'h10);
      r_data[k] = DW'(32'h1000_0000 + 32'(k));
    end
    drive_fields();
    do_reset();

    // single write from requester 0, engine done 5 cycles after o_en
    r_wr[0] = 1'b1; r_addr[0] = 32'h0002_0010; r_data[0] = 32'hA5A5_0001;
    drive_fields();
    bus.i_req = 4'b0001;
    run_txn(4, 0, 1, '0, g, dn, er, rd);
    check("wr0_grant", g, 4'b0001);
    check("wr0_done",  dn, 4'b0001);
    check("wr0_err",   er, 4'b0000);

    // all four requesting, re-asserting after each done
    do_reset();
    rr_order[0] = 4'b0001; rr_order[1] = 4'b0010; rr_order[2] = 4'b0100;
    rr_order[3] = 4'b1000; rr_order[4] = 4'b0001;
    bus.i_req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      run_txn(2, 0, 1, '0, g, dn, er, rd);
      check("rr_grant", g, rr_order[i]);
      bus.i_req = 4'b1111;
    end

    // after reset, requesters 2 and 3 only
    do_reset();
    bus.i_req = 4'b1100;
    run_txn(1, 0, 1, '0, g, dn, er, rd);
    check("r23_first", g, 4'b0100);
    run_txn(1, 0, 1, '0, g, dn, er, rd);
    check("r23_second", g, 4'b1000);

    // read from requester 1, data and done together
    r_wr[1] = 1'b0; r_addr[1] = 32'h0002_0004;
    drive_fields();
    bus.i_req = 4'b0010;
    run_txn(3, 0, 1, 32'hDEAD_BEEF, g, dn, er, rd);
    check("rd1_done",  dn, 4'b0010);
    check("rd1_rdata", rd, 32'hDEAD_BEEF);

    // engine never responds: timeout abort, then a late done is ignored
    bus.i_req = 4'b0001;
    run_txn(NONE, 0, 1, '0, g, dn, er, rd);
    check("tmo_done", dn, 4'b0001);
    check("tmo_err",  er, 4'b0001);
    repeat (4) @(negedge clk);
    bus.i_done = 1'b1; bus.i_data_vld = 1'b1; bus.i_data = 32'h1234_5678;
    @(negedge clk);
    bus.i_done = 1'b0; bus.i_data_vld = 1'b0;
    check("late_busy",  bus.o_busy, 0);
    check("late_done",  bus.o_req_done, 0);
    check("late_rdata", bus.o_req_rdata, 32'hDEAD_BEEF);
    bus.i_req = 4'b0100;
    run_txn(2, 0, 1, '0, g, dn, er, rd);
    check("fresh_done", dn, 4'b0100);
    check("fresh_err",  er, 4'b0000);

    // done exactly on the terminal count is a success
    bus.i_req = 4'b1000;
    run_txn(TMO - 1, 0, 1, '0, g, dn, er, rd);
    check("term_done", dn, 4'b1000);
    check("term_err",  er, 4'b0000);

    // reset during WAIT with requesters 0 and 2 active
    bus.i_req = 4'b0101;
    repeat (3) @(negedge clk);
    check("prerst_busy", bus.o_busy, 1);
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    repeat (2) begin
      @(negedge clk);
      check("midrst_nodone", bus.o_req_done, 0);
    end
    rst     = 1'b0;
    m_ptr   = 0;
    m_rdata = '0;
    run_txn(2, 0, 1, '0, g, dn, er, rd);
    check("postrst_grant", g, 4'b0001);

    // randomized traffic with jittering requests and random engine latency
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        bus.i_req = '0;
        repeat ($urandom_range(1, 3)) begin
          @(negedge clk);
          check("rnd_idle_busy",  bus.o_busy, 0);
          check("rnd_idle_grant", bus.o_grant, 0);
        end
      end
      for (int k = 0; k < N; k++) begin
        r_wr[k]   = 1'($urandom_range(0, 1));
        r_addr[k] = $urandom;
        r_data[k] = $urandom;
      end
      drive_fields();
      if (bus.i_req == '0 || $urandom_range(0, 1) == 1)
        bus.i_req = N'($urandom_range(1, (1 << N) - 1));
      case ($urandom_range(0, 9))
        0:       run_txn(NONE, 1, 0, '0, g, dn, er, rd);
        1:       run_txn(TMO - 1, 1, 0, '0, g, dn, er, rd);
        default: run_txn(int'($urandom_range(0, 10)), 1, 0, '0, g, dn, er, rd);
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axil_req_arbiter.md
# axil_req_arbiter

Round-robin arbiter and sequencer that shares one AXI-Lite register-access engine (command port: en/wr/addr/data in, done/data/data_vld out) between `NUM_REQ` requesters, for example the RDMA init FSM, QP configuration and the status poller. It accepts one command at a time and issues it to the engine as a single-cycle enable. It waits for the engine's completion, bounded by a watchdog. It returns completion and read data to the winning requester.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2 to 8.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `TIMEOUT`, 1024: maximum cycles spent in WAIT before abort, at least 4.

Ports:
- `s_axi_lite_aclk`, in, 1: the single clock.
- `s_axi_lite_arst`, in, 1: reset, asynchronous, active-high.
- `i_req`, in, NUM_REQ: per-requester request level.
- `i_req_wr`, in, NUM_REQ: per-requester op code, using `op_read`/`op_write` from XRNIC_define.vh.
- `i_req_addr`, in, NUM_REQ*ADDR_W: packed addresses; requester k occupies bits [k*ADDR_W +: ADDR_W].
- `i_req_data`, in, NUM_REQ*DATA_W: packed write data, same packing.
- `o_req_done`, out, NUM_REQ: one-cycle completion pulse to the winner.
- `o_req_err`, out, NUM_REQ: one-cycle pulse, coincident with `o_req_done`, on timeout.
- `o_req_rdata`, out, DATA_W: shared read-data return.
- `o_grant`, out, NUM_REQ: one-hot index of the current owner; all zero in IDLE.
- `o_en`, out, 1: command strobe to the engine.
- `o_wr`, out, 1: op code to the engine.
- `o_addr`, out, ADDR_W: address to the engine.
- `o_data`, out, DATA_W: write data to the engine.
- `i_done`, in, 1: engine completion.
- `i_data`, in, DATA_W: engine read data.
- `i_data_vld`, in, 1: engine read-data valid.
- `o_busy`, out, 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any `i_req` bit is set, select the winner by round-robin search starting at pointer `rr_ptr`.
  - Latch the winner's wr/addr/data into `o_wr`/`o_addr`/`o_data`.
  - Set `o_grant` to the winner and move to ISSUE.
- ISSUE: drive `o_en`=1 for exactly this one cycle, clear the watchdog counter, then move to WAIT.
- WAIT:
  - When `i_data_vld` is high, capture `i_data` into `o_req_rdata`.
  - `i_done` moves the FSM to RESP with err=0.
  - If the watchdog reaches TIMEOUT-1 without `i_done`, move to RESP with err=1.
  - If `i_done` arrives in the same cycle as the terminal count, it is a success, not a timeout.
- RESP:
  - Pulse `o_req_done[winner]`, and `o_req_err[winner]` if err.
  - Set `rr_ptr` = (winner+1) mod NUM_REQ.
  - Clear `o_grant` and return to IDLE.
- `o_addr`, `o_wr` and `o_data` hold their values from IDLE latch until the next latch.
- `o_req_rdata` holds until the next `i_data_vld` capture. It is valid at the `o_req_done` pulse of a read.
- Requester contract:
  - Hold `i_req`, wr, addr and data stable until `o_req_done`.
  - Deassert `i_req` in the cycle after `o_req_done`.
  - `i_req` still high in IDLE after its own completion counts as a new request.
- `i_req` changes of non-owners never disturb an in-flight command.
- A requester dropping `i_req` before done does not cancel its command. It still receives the done pulse.
- `i_done` or `i_data_vld` arriving in IDLE, ISSUE or RESP (for example a late completion after a timeout) is ignored and not captured.
- After a timeout, the engine is not reset by this block. The arbiter does not re-issue until the next arbitration.

## Timing
- Reset values: all outputs 0; `rr_ptr` = 0; FSM in IDLE; watchdog counter 0.
- Reset asserted mid-operation aborts immediately to these values. No done or err pulse is generated.
- `i_req` high in IDLE at cycle t:
  - `o_grant` and command latched at edge t+1.
  - `o_en` high during cycle t+1.
  - WAIT from t+2.
- `i_done` sampled high in WAIT at cycle d: `o_req_done` high during cycle d+1, and IDLE at d+2.
- Minimum back-to-back spacing is 3 cycles of overhead, so the next `o_en` is no earlier than d+3. The engine returns to its idle state one cycle after asserting done, so `o_en` never hits a busy engine.
- Timeout: the counter is 0 in the first WAIT cycle. The terminal count occurs in WAIT cycle TIMEOUT, giving RESP exactly TIMEOUT cycles after WAIT entry.
- Outputs are registered except `o_busy`, which is decoded from state.

## Test plan
- Write from requester 0 only (addr 0x0002_0010, data 0xA5A5_0001); the engine model asserts done 5 cycles after `o_en`.
  - Required: one `o_en` with `o_wr`=`op_write` and matching addr/data.
  - Required: `o_req_done[0]` one cycle after `i_done`, err=0, `o_busy` low afterwards.
- All 4 requesters assert in the same cycle and re-assert after each done.
  - Required: grants in order 0,1,2,3,0.
  - Required: after reset, requesters 2 and 3 alone give grant 2 then 3.
- Read from requester 1 of addr 0x0002_0004; the model returns 0xDEAD_BEEF with `i_data_vld` and `i_done` in the same cycle.
  - Required: `o_req_rdata`=0xDEAD_BEEF during `o_req_done[1]`.
- TIMEOUT=16 with the engine never responding.
  - Required: `o_req_done[k]` and `o_req_err[k]` pulse 16 cycles after WAIT entry.
  - Required: a late `i_done` 5 cycles later is ignored, and a fresh request is served normally.
- `i_done` exactly at the terminal count (TIMEOUT=16).
  - Required: done with err=0.
- Reset asserted during WAIT with requesters 0 and 2 active.
  - Required: all outputs 0 immediately, no done pulse.
  - Required: after release, grant 0 first (`rr_ptr`=0).
